// File: rtl/pprx_pkg.sv
// Shared types and constants for the TX lane scheduler.
package pprx_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned SYNC_W    = 3;
  localparam int unsigned CNT_W     = 16;

  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'hBC;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // One output beat toward the serializer.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              valid;
    logic [LANE_W-1:0] lane;
  } beat_t;

  // Lane index k positions after base, wrapping over the four lanes.
  function automatic logic [LANE_W-1:0] lane_after(input logic [LANE_W-1:0] base,
                                                   input int unsigned k);
    return LANE_W'(base + LANE_W'(k));
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: search starts at the lane after ptr.
module rr_arbiter4
  import pprx_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    ptr,
  output logic [NUM_LANES-1:0] gnt,
  output logic [LANE_W-1:0]    idx,
  output logic                 any
);

  // Walk lanes ptr+1 .. ptr+4; first requester wins, lane ptr itself is last.
  always_comb begin
    logic [LANE_W-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 1; k <= NUM_LANES; k++) begin
      cand = lane_after(ptr, k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/tx_lane_scheduler.sv
// Round-robin byte scheduler: merges four lanes into one serializer byte stream
// after a short idle-byte sync preamble.
module tx_lane_scheduler
  import pprx_pkg::*;
#(
  parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEF,
  parameter int unsigned INIT_CYCLES = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] lane_mask,
  input  logic [7:0] data_0p,
  input  logic [7:0] data_1p,
  input  logic [7:0] data_2p,
  input  logic [7:0] data_3p,
  input  logic       valid_0p,
  input  logic       valid_1p,
  input  logic       valid_2p,
  input  logic       valid_3p,
  output logic       ready_0p,
  output logic       ready_1p,
  output logic       ready_2p,
  output logic       ready_3p,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_sel,
  output logic       active
);

  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(INIT_CYCLES - 1);
  localparam logic [LANE_W-1:0] PTR_RST   = LANE_W'(NUM_LANES - 1);

  state_e               state_q, state_d;
  logic [SYNC_W-1:0]    sync_cnt_q;
  logic [LANE_W-1:0]    ptr_q;
  logic [CNT_W-1:0]     sent_count_q;

  logic [BYTE_W-1:0]    lane_data [NUM_LANES];
  logic [NUM_LANES-1:0] valid_vec;
  logic [NUM_LANES-1:0] arb_req;
  logic [NUM_LANES-1:0] arb_gnt;
  logic [LANE_W-1:0]    arb_idx;
  logic                 arb_any;

  logic [NUM_LANES-1:0] ready_vec;
  logic                 xfer;
  beat_t                beat_d;

  assign lane_data[0] = data_0p;
  assign lane_data[1] = data_1p;
  assign lane_data[2] = data_2p;
  assign lane_data[3] = data_3p;
  assign valid_vec    = {valid_3p, valid_2p, valid_1p, valid_0p};

  // Only RUN with enable held high may grant; mask gates lanes the same cycle.
  assign arb_req = (state_q == ST_RUN && enable) ? (valid_vec & lane_mask) : '0;

  rr_arbiter4 u_arb (
    .req (arb_req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // State register.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) state_q <= ST_OFF;
    else       state_q <= state_d;
  end

  // Next-state logic: enable low always returns to OFF.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (enable) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!enable)                     state_d = ST_OFF;
        else if (sync_cnt_q == SYNC_LAST) state_d = ST_RUN;
      end
      ST_RUN:  if (!enable) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase
  end

  // Output logic: grant lines and the beat to be registered this edge.
  always_comb begin
    ready_vec = '0;
    xfer      = 1'b0;
    beat_d    = '{data: IDLE_BYTE, valid: 1'b0, lane: lane_sel};
    if (arb_any) begin
      ready_vec = arb_gnt;
      xfer      = 1'b1;
      beat_d    = '{data: lane_data[arb_idx], valid: 1'b1, lane: arb_idx};
    end
  end

  assign ready_0p = ready_vec[0];
  assign ready_1p = ready_vec[1];
  assign ready_2p = ready_vec[2];
  assign ready_3p = ready_vec[3];

  // SYNC dwell counter: cleared on entry, counts only while in SYNC.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      sync_cnt_q <= '0;
    end else if (state_q != ST_SYNC && state_d == ST_SYNC) begin
      sync_cnt_q <= '0;
    end else if (state_q == ST_SYNC) begin
      sync_cnt_q <= SYNC_W'(sync_cnt_q + SYNC_W'(1));
    end
  end

  // Registered outputs, round-robin pointer and debug transfer count.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      data_out     <= IDLE_BYTE;
      valid_out    <= 1'b0;
      lane_sel     <= '0;
      active       <= 1'b0;
      ptr_q        <= PTR_RST;
      sent_count_q <= '0;
    end else begin
      data_out  <= beat_d.data;
      valid_out <= beat_d.valid;
      lane_sel  <= beat_d.lane;
      active    <= (state_d == ST_RUN);
      if (xfer) begin
        ptr_q        <= arb_idx;
        sent_count_q <= CNT_W'(sent_count_q + CNT_W'(1));
      end
    end
  end

endmodule

// File: doc/tx_lane_scheduler.md
TX_LANE_SCHEDULER -- requirements
Module: tx_lane_scheduler

Interface
REQ-001 SHALL have parameter IDLE_BYTE, default 8'hBC, byte emitted on data_out when no lane is transferred.
REQ-002 SHALL have parameter INIT_CYCLES, default 4, number of IDLE_BYTE cycles sent in SYNC before RUN.
REQ-003 SHALL have port clk_4f  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  link enable; 1 starts or keeps scheduling, 0 stops it.
REQ-006 SHALL have port lane_mask  input  4  per-lane enable; bit i gates lane i.
REQ-007 SHALL have ports data_0p..data_3p  input  8 each  lane payload bytes.
REQ-008 SHALL have ports valid_0p..valid_3p  input  1 each  lane i presents a byte.
REQ-009 SHALL have ports ready_0p..ready_3p  output  1 each  combinational grant; a transfer occurs when valid_ip and ready_ip are both 1 at an edge.
REQ-010 SHALL have port data_out  output  8  registered byte to the serializer.
REQ-011 SHALL have port valid_out  output  1  registered; 1 when data_out carries lane payload.
REQ-012 SHALL have port lane_sel  output  2  registered index of the lane carried on data_out.
REQ-013 SHALL have port active  output  1  registered; 1 only in state RUN.

Function
REQ-014 SHALL implement FSM states OFF, SYNC and RUN.
REQ-015 Transitions: OFF->SYNC when enable=1; SYNC->RUN after exactly INIT_CYCLES cycles in SYNC; SYNC or RUN->OFF when enable=0; all other cases hold.
REQ-016 In OFF and SYNC: all ready_ip=0, data_out=IDLE_BYTE, valid_out=0.
REQ-017 In RUN, a lane is eligible when valid_ip=1 and lane_mask[i]=1.
REQ-018 Grant policy is round-robin: search starts at lane ptr+1 mod 4; the first eligible lane gets ready=1. At most one ready is high per cycle.
REQ-019 ptr SHALL update to the granted lane on every transfer and SHALL hold when there is no transfer.
REQ-020 Latency: a byte transferred at edge N appears on data_out at edge N, registered, with valid_out=1 and lane_sel equal to the granted lane.
REQ-021 A RUN cycle with no eligible lane SHALL produce data_out=IDLE_BYTE and valid_out=0; lane_sel holds its value.
REQ-022 A change to lane_mask SHALL take effect in the same cycle; lane_mask=0 yields continuous idle output.
REQ-023 When enable=0 in RUN, there SHALL be no grant in that cycle and the next output SHALL be idle.
REQ-024 A 3-bit SYNC counter SHALL clear on entry to SYNC and SHALL be unused elsewhere.
REQ-025 A 16-bit sent_count SHALL increment on each transfer, wrap at 16'hFFFF->0, and be available internally for debug.

Reset
REQ-026 reset=1 SHALL force, asynchronously: state=OFF, data_out=IDLE_BYTE, valid_out=0, lane_sel=0, active=0, ptr=3 (lane 0 first), counters=0, all ready=0.
REQ-027 Reset during RUN SHALL abort a transfer in progress; no byte SHALL be emitted for that cycle.

Structure
REQ-028 Shared package pprx_pkg SHALL hold the FSM state encodings, the IDLE_BYTE default and the lane count (4).
REQ-029 The round-robin logic SHALL be sub-module rr_arbiter4 (inputs: req[3:0], ptr[1:0]; outputs: one-hot gnt[3:0], idx[1:0], any).

Verification
REQ-030 Reset, then enable=1 at cycle 0 -> 4 cycles of data_out=8'hBC with active=0; active=1 from cycle 5.
REQ-031 RUN with all four lanes valid, data_ip=8'h10+i, mask=4'hF -> data_out sequence 10,11,12,13,10..., lane_sel 0,1,2,3,0, valid_out=1 every cycle.
REQ-032 RUN with only lanes 1 and 3 valid -> alternating lane_sel 1,3,1; lanes 0 and 2 never see ready.
REQ-033 Lanes valid but lane_mask=4'b0000 -> data_out=8'hBC, valid_out=0, no ready asserted; then mask=4'b0100 -> lane 2 is granted in the same cycle.
REQ-034 enable dropped mid-burst -> no grant that cycle; next data_out=8'hBC; active=0 and state=OFF.
REQ-035 reset asserted between edges during RUN -> outputs immediately at reset values; after release and re-enable, lane 0 is granted first.
